// File: rtl/nubus_mem2wb.sv
// nubus_mem2wb
// Bridges the level-sensitive memory port of a NuBus slave FSM onto a
// Wishbone B4 classic master. Each NuBus access produces exactly one
// Wishbone cycle, which ends in one of three ways:
//   - termination by wb_ack or wb_err
//   - watchdog timeout
//   - asynchronous reset
//
// Parameters
//   WB_AW  Wishbone word-address width (byte address bits [WB_AW+1:2])
//   WDT_W  watchdog width; an unterminated cycle aborts after 2^WDT_W cycles
//
// Ports
//   nub_clkn      in   NuBus clock, all flops on its rising edge
//   nub_resetn    in   asynchronous active-low reset
//   mem_valid     in   access request (level, held for the whole access)
//   mem_addr      in   byte address
//   mem_wdata     in   write data
//   mem_write     in   byte write enables, 0000 = read
//   mem_ready     out  one-cycle completion pulse
//   mem_rdata     out  read data, held until the next completed read
//   mem_error     out  qualifies mem_ready: bus error or timeout
//   mem_tryagain  out  constant 0
//   wb_cyc/stb/we out  Wishbone master controls (registered)
//   wb_adr        out  word address
//   wb_dat_w      out  write data
//   wb_sel        out  byte selects
//   wb_dat_r      in   read data
//   wb_ack/err    in   Wishbone termination
module nubus_mem2wb #(
    parameter int WB_AW = 30,
    parameter int WDT_W = 8
) (
    input  logic             nub_clkn,
    input  logic             nub_resetn,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_write,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             mem_error,
    output logic             mem_tryagain,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [WB_AW-1:0] wb_adr,
    output logic [31:0]      wb_dat_w,
    output logic [3:0]       wb_sel,
    input  logic [31:0]      wb_dat_r,
    input  logic             wb_ack,
    input  logic             wb_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP,
        S_WAITLOW
    } state_t;

    state_t           r_state;
    logic [WDT_W-1:0] r_wdt;
    logic             r_abort;

    logic w_term;
    logic w_timeout;
    logic w_drop;
    logic w_is_write;
    logic w_unused;

    assign w_term     = wb_ack | wb_err;
    // Counter at all-ones means this BUS cycle is the last one before wrap.
    assign w_timeout  = (r_wdt == {WDT_W{1'b1}}) & ~w_term;
    // NuBus master gave up: either earlier in BUS or on this very cycle.
    assign w_drop     = r_abort | ~mem_valid;
    assign w_is_write = |mem_write;
    // Byte-lane bits never reach the word-addressed Wishbone side.
    assign w_unused   = &{1'b0, mem_addr[1:0]};

    assign mem_tryagain = 1'b0;

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            r_state   <= S_IDLE;
            r_wdt     <= '0;
            r_abort   <= 1'b0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= '0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            wb_adr    <= '0;
            wb_dat_w  <= '0;
            wb_sel    <= '0;
        end else begin
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_we    <= w_is_write;
                        wb_sel   <= w_is_write ? mem_write : 4'b1111;
                        wb_adr   <= mem_addr[WB_AW+1:2];
                        wb_dat_w <= mem_wdata;
                        r_wdt    <= '0;
                        r_abort  <= 1'b0;
                        r_state  <= S_BUS;
                    end
                end
                S_BUS: begin
                    r_wdt <= r_wdt + 1'b1;
                    if (!mem_valid) r_abort <= 1'b1;
                    if (w_term || w_timeout) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        wb_we  <= 1'b0;
                        if (w_drop) begin
                            // Aborted access: cycle finished, nobody to answer.
                            r_state <= S_WAITLOW;
                        end else begin
                            r_state   <= S_RESP;
                            mem_ready <= 1'b1;
                            // Only a clean ack is a success; err (with or
                            // without ack) and timeout are errors.
                            mem_error <= wb_err | ~wb_ack;
                            if (wb_ack && !wb_err && !wb_we) mem_rdata <= wb_dat_r;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_WAITLOW;
                end
                S_WAITLOW: begin
                    // Wait for the slave FSM to release the request so one
                    // access never produces a second Wishbone cycle.
                    if (!mem_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_mem2wb.sv
// Testbench for nubus_mem2wb: vector table of accesses driven against a
// behavioural Wishbone slave, with expected responses queued per access and
// matched when mem_ready pulses; plus hand sequences for abort and reset.
module tb_nubus_mem2wb;

    localparam int WB_AW = 30;
    localparam int WDT_W = 4;

    logic             nub_clkn = 1'b0;
    logic             nub_resetn = 1'b0;
    logic             mem_valid = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic [3:0]       mem_write = '0;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             mem_error;
    logic             mem_tryagain;
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [WB_AW-1:0] wb_adr;
    logic [31:0]      wb_dat_w;
    logic [3:0]       wb_sel;
    logic [31:0]      wb_dat_r = 32'hA5A5A5A5;
    logic             wb_ack = 1'b0;
    logic             wb_err = 1'b0;

    nubus_mem2wb #(.WB_AW(WB_AW), .WDT_W(WDT_W)) dut (
        .nub_clkn    (nub_clkn),
        .nub_resetn  (nub_resetn),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_error   (mem_error),
        .mem_tryagain(mem_tryagain),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_w    (wb_dat_w),
        .wb_sel      (wb_sel),
        .wb_dat_r    (wb_dat_r),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err)
    );

    always #5 nub_clkn = ~nub_clkn;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  write;
        int          term;      // BUS cycle on which slave terminates, 0 = never
        logic        ack;
        logic        err;
        logic [31:0] dat_r;
        int          hold;      // extra cycles mem_valid stays high after the end
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_bus;   // expected BUS length, 0 = unchecked
        int          exp_lat;   // expected mem_valid->mem_ready latency, 0 = unchecked
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc_n = 0;
    int   ready_count = 0;
    int   ready_cyc = 0;
    int   cyc_count = 0;
    int   err_wo_ready = 0;
    logic prev_cyc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Output monitor: samples exactly on the falling edge.
    always @(negedge nub_clkn) begin
        exp_t e;
        cyc_n++;
        if (wb_cyc && !prev_cyc) cyc_count++;
        prev_cyc = wb_cyc;
        if (mem_error && !mem_ready) err_wo_ready++;
        if (mem_ready) begin
            ready_count++;
            ready_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", mem_rdata, e.rdata);
                check("error", {31'd0, mem_error}, {31'd0, e.err});
            end
        end
    end

    // Advance to just after the falling edge (after the monitor sampled).
    task automatic tick;
        @(negedge nub_clkn);
        #1;
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (!wb_cyc && n < 10) begin tick(); n++; end
        check(name, {31'd0, wb_cyc}, 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   c0, r0, y0, bus;
        bit   done;
        exp_t e;
        r0 = ready_count;
        y0 = cyc_count;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_write = v.write;
        mem_valid = 1'b1;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        exp_q.push_back(e);
        c0 = cyc_n;
        tick();
        wait_cyc({tag, "_cyc"});
        check({tag, "_stb"},  {31'd0, wb_stb}, 32'd1);
        check({tag, "_adr"},  {2'd0, wb_adr}, v.exp_adr);
        check({tag, "_sel"},  {28'd0, wb_sel}, {28'd0, v.exp_sel});
        check({tag, "_we"},   {31'd0, wb_we}, {31'd0, v.exp_we});
        check({tag, "_datw"}, wb_dat_w, v.wdata);
        bus = 0;
        done = 0;
        while (!done) begin
            bus++;
            if (bus == v.term) begin
                wb_ack = v.ack;
                wb_err = v.err;
                wb_dat_r = v.dat_r;
            end
            tick();
            wb_ack = 1'b0;
            wb_err = 1'b0;
            wb_dat_r = 32'hA5A5A5A5;
            if (!wb_cyc || bus >= 40) done = 1;
        end
        if (v.exp_bus != 0) check({tag, "_buslen"}, bus, v.exp_bus);
        if (v.exp_lat != 0) check({tag, "_latency"}, ready_cyc - c0 + 1, v.exp_lat);
        repeat (v.hold) tick();
        mem_valid = 1'b0;
        repeat (3) tick();
        check({tag, "_ready_pulses"}, ready_count - r0, 1);
        check({tag, "_wb_cycles"}, cyc_count - y0, 1);
    endtask

    vec_t vecs[8];

    initial begin
        int   r0, y0, n;
        vec_t va, vr;

        //          addr          wdata         wr      term ack err dat_r         hold exp_adr       sel     we  exp_rdata     err bus lat
        vecs[0] = '{32'hF000_0010, 32'h0,        4'b0000, 2, 1, 0, 32'hDEADBEEF, 0, 32'h3C00_0004, 4'b1111, 0, 32'hDEADBEEF, 0, 2,  0};
        vecs[1] = '{32'h0000_1004, 32'h00AB_0000, 4'b0100, 1, 1, 0, 32'h0,        0, 32'h0000_0401, 4'b0100, 1, 32'hDEADBEEF, 0, 1,  0};
        vecs[2] = '{32'h1234_5678, 32'h0,        4'b0000, 1, 1, 0, 32'h0BADF00D, 0, 32'h048D_159E, 4'b1111, 0, 32'h0BADF00D, 0, 1,  3};
        vecs[3] = '{32'h0000_0008, 32'h0,        4'b0000, 1, 0, 1, 32'hFFFFFFFF, 10, 32'h0000_0002, 4'b1111, 0, 32'h0BADF00D, 1, 1,  0};
        vecs[4] = '{32'h0000_000C, 32'h0,        4'b0000, 3, 1, 1, 32'h12345678, 0, 32'h0000_0003, 4'b1111, 0, 32'h0BADF00D, 1, 3,  0};
        vecs[5] = '{32'h0000_0020, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        0, 32'h0000_0008, 4'b1111, 0, 32'h0BADF00D, 1, 16, 0};
        vecs[6] = '{32'hFFFF_FFFC, 32'h1122_3344, 4'b1111, 1, 1, 0, 32'h0,        0, 32'h3FFF_FFFF, 4'b1111, 1, 32'h0BADF00D, 0, 1,  0};
        vecs[7] = '{32'h0000_0040, 32'h0,        4'b0000, 4, 1, 0, 32'h13579BDF, 0, 32'h0000_0010, 4'b1111, 0, 32'h13579BDF, 0, 4,  0};
        va      = '{32'h2000_0000, 32'h0,        4'b0000, 1, 1, 0, 32'h2468ACE0, 0, 32'h0800_0000, 4'b1111, 0, 32'h2468ACE0, 0, 1,  3};
        vr      = '{32'h0000_0100, 32'h0,        4'b0000, 2, 1, 0, 32'h0F0F0F0F, 0, 32'h0000_0040, 4'b1111, 0, 32'h0F0F0F0F, 0, 2,  0};

        // Reset state
        tick();
        tick();
        check("rst_cyc",   {31'd0, wb_cyc}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_adr",   {2'd0, wb_adr}, 32'd0);
        check("rst_try",   {31'd0, mem_tryagain}, 32'd0);
        nub_resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Aborted write: mem_valid drops in BUS cycle 1, ack arrives in cycle 4.
        r0 = ready_count;
        y0 = cyc_count;
        mem_addr  = 32'h0000_0100;
        mem_wdata = 32'hCAFE_0001;
        mem_write = 4'b0011;
        mem_valid = 1'b1;
        tick();
        wait_cyc("abort_cyc");
        mem_valid = 1'b0;
        repeat (3) tick();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("abort_cyc_drop", {31'd0, wb_cyc}, 32'd0);
        repeat (3) tick();
        check("abort_no_ready", ready_count - r0, 0);
        check("abort_wb_cycles", cyc_count - y0, 1);
        check("abort_rdata", mem_rdata, 32'h13579BDF);
        run_vec("after_abort", va);

        // Reset in the middle of a BUS cycle.
        mem_addr  = 32'hF000_0010;
        mem_write = 4'b0000;
        mem_valid = 1'b1;
        tick();
        wait_cyc("rstbus_cyc");
        tick();
        nub_resetn = 1'b0;
        #1;
        check("rstbus_cyc0",  {31'd0, wb_cyc}, 32'd0);
        check("rstbus_stb0",  {31'd0, wb_stb}, 32'd0);
        check("rstbus_we0",   {31'd0, wb_we}, 32'd0);
        check("rstbus_sel0",  {28'd0, wb_sel}, 32'd0);
        check("rstbus_adr0",  {2'd0, wb_adr}, 32'd0);
        check("rstbus_datw0", wb_dat_w, 32'd0);
        check("rstbus_ready0", {31'd0, mem_ready}, 32'd0);
        check("rstbus_err0",  {31'd0, mem_error}, 32'd0);
        check("rstbus_rdata0", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        tick();
        tick();
        nub_resetn = 1'b1;
        n = 0;
        repeat (3) begin tick(); if (wb_cyc) n++; end
        check("rstbus_stay_idle", n, 0);
        run_vec("post_reset", vr);

        check("err_without_ready", err_wo_ready, 0);
        check("pending_expect", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
